// File: rtl/ternary_vector_pe.sv
// ternary_vector_pe: LANES-wide ternary multiply-accumulate with a two-stage pipeline,
// per-lane zero-skip counters, optional saturation and a flush/snapshot handshake.
module ternary_vector_pe #(
  parameter int LANES = 8,
  parameter int ACC_W = 32,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2*LANES-1:0]       weight,
  input  logic [2*LANES-1:0]       trit_in,
  input  logic [31:0]              exec_hints,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*ACC_W-1:0]   acc_out,
  output logic [LANES*CNT_W-1:0]   skip_count,
  output logic [LANES-1:0]         ovf
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  localparam logic [7:0] OP_DOT   = 8'h01;
  localparam logic [7:0] OP_MUL   = 8'h03;
  localparam logic [7:0] OP_TGEMM = 8'h06;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic trit_is_zero(input logic [1:0] code);
    return (code == 2'b00) || (code == 2'b11);
  endfunction

  // Product as 2-bit two's complement: 01 = +1, 11 = -1, 00 = 0.
  function automatic logic [1:0] trit_mul(input logic [1:0] w, input logic [1:0] x);
    logic [1:0] p;
    if (trit_is_zero(w) || trit_is_zero(x)) begin
      p = 2'b00;
    end else if (w == x) begin
      p = 2'b01;
    end else begin
      p = 2'b11;
    end
    return p;
  endfunction

  logic [1:0]                  state_q, state_d;
  logic                        clr_on_read_q, clr_on_read_d;

  logic                        s1_valid_q, s1_valid_d;
  logic [LANES-1:0][1:0]       s1_prod_q, s1_prod_d;
  logic [LANES-1:0]            s1_skip_q, s1_skip_d;
  logic [7:0]                  s1_op_q, s1_op_d;
  logic                        s1_sat_q, s1_sat_d;

  logic [LANES-1:0][ACC_W-1:0] acc_q, acc_d;
  logic [LANES-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [LANES-1:0]            ovf_q, ovf_d;

  logic [LANES-1:0][ACC_W:0]   sum_s;
  logic                        accept_s;
  logic                        flush_take_s;
  logic                        clear_s;
  logic                        unused_hints_s;

  assign in_ready     = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
  assign out_valid    = (state_q == ST_OUT);
  assign accept_s     = in_valid && in_ready;
  assign flush_take_s = flush && in_ready;
  assign clear_s      = (state_q == ST_OUT) && out_ready && clr_on_read_q;

  assign acc_out    = acc_q;
  assign skip_count = cnt_q;
  assign ovf        = ovf_q;

  assign unused_hints_s = ^{exec_hints[31:20], exec_hints[16:8]};

  always_comb begin
    s1_valid_d = 1'b0;
    s1_prod_d  = s1_prod_q;
    s1_skip_d  = s1_skip_q;
    s1_op_d    = s1_op_q;
    s1_sat_d   = s1_sat_q;
    if (accept_s) begin
      s1_valid_d = 1'b1;
      s1_op_d    = exec_hints[7:0];
      s1_sat_d   = exec_hints[18];
      for (int i = 0; i < LANES; i++) begin
        s1_prod_d[i] = trit_mul(weight[2*i +: 2], trit_in[2*i +: 2]);
        s1_skip_d[i] = exec_hints[17] &&
                       (trit_is_zero(weight[2*i +: 2]) || trit_is_zero(trit_in[2*i +: 2]));
      end
    end else begin
      s1_valid_d = 1'b0;
    end
  end

  // One guard bit lets the top two bits of the sum expose signed overflow.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      sum_s[i] = {acc_q[i][ACC_W-1], acc_q[i]} +
                 {{(ACC_W-1){s1_prod_q[i][1]}}, s1_prod_q[i]};
    end
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clear_s) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = '0;
    end else if (s1_valid_q) begin
      for (int i = 0; i < LANES; i++) begin
        if (s1_skip_q[i]) begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end else begin
          cnt_d[i] = cnt_q[i];
        end
        case (s1_op_q)
          OP_DOT, OP_TGEMM: begin
            if (s1_skip_q[i]) begin
              acc_d[i] = acc_q[i];
            end else if (sum_s[i][ACC_W] != sum_s[i][ACC_W-1]) begin
              ovf_d[i] = 1'b1;
              if (s1_sat_q) begin
                acc_d[i] = sum_s[i][ACC_W] ? ACC_MIN : ACC_MAX;
              end else begin
                acc_d[i] = sum_s[i][ACC_W-1:0];
              end
            end else begin
              acc_d[i] = sum_s[i][ACC_W-1:0];
            end
          end
          OP_MUL:  acc_d[i] = {{(ACC_W-2){s1_prod_q[i][1]}}, s1_prod_q[i]};
          default: acc_d[i] = acc_q[i];
        endcase
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // DRAIN waits only on stage 1; the accumulators are stage 2 themselves.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (flush_take_s) begin
          state_d = ST_DRAIN;
        end else if (accept_s) begin
          state_d = ST_ACCUM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (flush_take_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_DRAIN: begin
        if (!s1_valid_q) begin
          state_d = ST_OUT;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush_take_s) begin
      clr_on_read_d = exec_hints[19];
    end else begin
      clr_on_read_d = clr_on_read_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      clr_on_read_q <= 1'b0;
      s1_valid_q    <= 1'b0;
      s1_prod_q     <= '0;
      s1_skip_q     <= '0;
      s1_op_q       <= 8'h00;
      s1_sat_q      <= 1'b0;
      acc_q         <= '0;
      cnt_q         <= '0;
      ovf_q         <= '0;
    end else begin
      state_q       <= state_d;
      clr_on_read_q <= clr_on_read_d;
      s1_valid_q    <= s1_valid_d;
      s1_prod_q     <= s1_prod_d;
      s1_skip_q     <= s1_skip_d;
      s1_op_q       <= s1_op_d;
      s1_sat_q      <= s1_sat_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      ovf_q         <= ovf_d;
    end
  end

endmodule

// File: tb/tb_ternary_vector_pe.sv
// Directed bench for ternary_vector_pe (LANES=4, ACC_W=8, CNT_W=8): a beat table with
// hand-computed running totals, then flush, clear-on-read, reset and saturation sequences.
module tb_ternary_vector_pe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  weight;
  logic [7:0]  trit_in;
  logic [31:0] exec_hints;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] acc_out;
  logic [31:0] skip_count;
  logic [3:0]  ovf;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0]  w;
    logic [7:0]  x;
    logic [31:0] hints;
    logic [31:0] exp_acc;
    logic [31:0] exp_skip;
  } vec_t;

  vec_t tbl [0:14];

  ternary_vector_pe #(.LANES(4), .ACC_W(8), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .weight     (weight),
    .trit_in    (trit_in),
    .exec_hints (exec_hints),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .acc_out    (acc_out),
    .skip_count (skip_count),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_zero_idle(input string tag);
    chk({tag, " acc"},       acc_out, 32'h0);
    chk({tag, " skip"},      skip_count, 32'h0);
    chk({tag, " ovf"},       32'(ovf), 32'h0);
    chk({tag, " out_valid"}, 32'(out_valid), 32'h0);
    chk({tag, " in_ready"},  32'(in_ready), 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Lanes packed lane3..lane0; acc/skip bytes likewise.
    tbl[0]  = '{8'h01, 8'h01, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000};
    tbl[1]  = '{8'h01, 8'h01, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000};
    tbl[2]  = '{8'h01, 8'h01, 32'h0000_0001, 32'h0000_0003, 32'h0000_0000};
    tbl[3]  = '{8'hE0, 8'h58, 32'h0002_0001, 32'h00FF_0003, 32'h0100_0101};
    tbl[4]  = '{8'hE0, 8'h58, 32'h0002_0001, 32'h00FE_0003, 32'h0200_0202};
    tbl[5]  = '{8'hE0, 8'h58, 32'h0002_0001, 32'h00FD_0003, 32'h0300_0303};
    tbl[6]  = '{8'hE0, 8'h58, 32'h0002_0001, 32'h00FC_0003, 32'h0400_0404};
    tbl[7]  = '{8'hE0, 8'h58, 32'h0002_0001, 32'h00FB_0003, 32'h0500_0505};
    tbl[8]  = '{8'h01, 8'h01, 32'h0000_0001, 32'h00FB_0004, 32'h0500_0505};
    tbl[9]  = '{8'h01, 8'h01, 32'h0000_0001, 32'h00FB_0005, 32'h0500_0505};
    tbl[10] = '{8'h01, 8'h01, 32'h0000_0001, 32'h00FB_0006, 32'h0500_0505};
    tbl[11] = '{8'h01, 8'h01, 32'h0000_0001, 32'h00FB_0007, 32'h0500_0505};
    tbl[12] = '{8'hC6, 8'h4A, 32'h0002_0003, 32'h0000_FF01, 32'h0601_0505};
    tbl[13] = '{8'h15, 8'h55, 32'h0002_0000, 32'h0000_FF01, 32'h0701_0505};
    tbl[14] = '{8'h55, 8'h55, 32'h0000_0006, 32'h0101_0002, 32'h0701_0505};

    reset = 1'b1; in_valid = 1'b0; weight = 8'h00; trit_in = 8'h00;
    exec_hints = 32'h0; flush = 1'b0; out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk_zero_idle("reset");

    for (int k = 0; k < 15; k++) begin
      weight = tbl[k].w; trit_in = tbl[k].x; exec_hints = tbl[k].hints; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      chk($sformatf("tbl%0d acc", k),  acc_out, tbl[k].exp_acc);
      chk($sformatf("tbl%0d skip", k), skip_count, tbl[k].exp_skip);
      chk($sformatf("tbl%0d ovf", k),  32'(ovf), 32'h0);
    end

    // Flush from ACCUM with empty pipeline, clear_on_read=1, consumer stalls 4 cycles.
    flush = 1'b1; exec_hints = 32'h0008_0000;
    step();
    flush = 1'b0; exec_hints = 32'h0000_0001;
    chk("drain out_valid", 32'(out_valid), 32'h0);
    chk("drain in_ready",  32'(in_ready), 32'h0);
    step();
    for (int c = 0; c < 4; c++) begin
      weight = 8'h55; trit_in = 8'h55; in_valid = 1'b1;
      chk($sformatf("stall%0d out_valid", c), 32'(out_valid), 32'h1);
      chk($sformatf("stall%0d in_ready", c),  32'(in_ready), 32'h0);
      chk($sformatf("stall%0d acc", c),       acc_out, 32'h0101_0002);
      chk($sformatf("stall%0d skip", c),      skip_count, 32'h0701_0505);
      step();
    end
    in_valid = 1'b0;
    chk("stall end acc", acc_out, 32'h0101_0002);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk_zero_idle("clear_on_read");

    // Beat accepted in the flush cycle must land in the snapshot; DRAIN takes 2 cycles.
    weight = 8'h01; trit_in = 8'h01; exec_hints = 32'h0000_0001; in_valid = 1'b1; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    chk("flushbeat drain1 out_valid", 32'(out_valid), 32'h0);
    chk("flushbeat drain1 in_ready",  32'(in_ready), 32'h0);
    step();
    chk("flushbeat drain2 out_valid", 32'(out_valid), 32'h0);
    step();
    chk("flushbeat out_valid", 32'(out_valid), 32'h1);
    chk("flushbeat acc",       acc_out, 32'h0000_0001);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("noclear out_valid", 32'(out_valid), 32'h0);
    chk("noclear in_ready",  32'(in_ready), 32'h1);
    chk("noclear acc",       acc_out, 32'h0000_0001);

    // Reset while in OUT with a beat and flush presented.
    flush = 1'b1; exec_hints = 32'h0;
    step();
    flush = 1'b0;
    step();
    chk("pre-reset out_valid", 32'(out_valid), 32'h1);
    reset = 1'b1; in_valid = 1'b1; flush = 1'b1; exec_hints = 32'h0000_0001;
    step();
    reset = 1'b0; in_valid = 1'b0; flush = 1'b0;
    chk_zero_idle("reset_in_out");
    step();
    step();
    chk("post-reset acc", acc_out, 32'h0);

    // Beat sitting in stage 1 when reset hits is discarded.
    in_valid = 1'b1;
    step();
    in_valid = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("s1 discard acc", acc_out, 32'h0);
    chk("s1 discard in_ready", 32'(in_ready), 32'h1);

    // 130 beats of +1 with saturation, then with wrap.
    weight = 8'h01; trit_in = 8'h01; exec_hints = 32'h0004_0001; in_valid = 1'b1;
    for (int n = 0; n < 130; n++) step();
    in_valid = 1'b0;
    step();
    chk("sat acc", acc_out, 32'h0000_007F);
    chk("sat ovf", 32'(ovf), 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("sat reset ovf", 32'(ovf), 32'h0);
    exec_hints = 32'h0000_0001; in_valid = 1'b1;
    for (int n = 0; n < 130; n++) step();
    in_valid = 1'b0;
    step();
    chk("wrap acc", acc_out, 32'h0000_0082);
    chk("wrap ovf", 32'(ovf), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ternary_vector_pe.md
TERNARY_VECTOR_PE -- requirements
Module: ternary_vector_pe

Interface
REQ-001 Parameter LANES, default 8, meaning number of parallel ternary lanes (1..64).
REQ-002 Parameter ACC_W, default 32, meaning per-lane signed accumulator width (8..64).
REQ-003 Parameter CNT_W, default 32, meaning width of each per-lane zero-skip counter.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  input beat valid.
REQ-007 in_ready  output  1  block can accept a beat.
REQ-008 weight  input  2*LANES  lane i weight at [2i+1:2i]; encoding 00=0, 01=+1, 10=-1, 11=0.
REQ-009 trit_in  input  2*LANES  lane i input trit at [2i+1:2i]; same encoding.
REQ-010 exec_hints  input  32  [7:0] op_mode, [17] zero_skip_en, [18] sat_en, [19] clear_on_read; sampled per accepted beat.
REQ-011 flush  input  1  request to publish accumulators; sampled only when in_ready=1.
REQ-012 out_valid  output  1  accumulator snapshot valid.
REQ-013 out_ready  input  1  consumer accepts snapshot.
REQ-014 acc_out  output  LANES*ACC_W  lane i accumulator at [(i+1)*ACC_W-1:i*ACC_W].
REQ-015 skip_count  output  LANES*CNT_W  per-lane zero-skip counters, same packing.
REQ-016 ovf  output  LANES  per-lane sticky overflow/saturation flag.

Function
REQ-017 Beat accepted iff in_valid && in_ready; weight, trit_in, exec_hints registered together in stage 1.
REQ-018 Stage 1 (edge after acceptance): per-lane product = w*x in {-1,0,+1}; code 11 on either operand treated as 0.
REQ-019 Skip condition per lane: zero_skip_en && (w is 0 or 11 || x is 0 or 11); computed in stage 1.
REQ-020 Stage 2 (second edge after acceptance): accumulator/skip_count update; net latency accept-to-acc_out = 2 cycles.
REQ-021 op_mode 8'h01 (DOT) or 8'h06 (TGEMM): acc += sign-extended product unless lane skipped; skipped lane holds acc.
REQ-022 op_mode 8'h03 (MUL): acc = sign-extended product, independent of skip.
REQ-023 Any other op_mode: acc holds; beat still consumed; skip counting still applies.
REQ-024 skip_count increments by 1 per skipped lane per beat in every op_mode; wraps at 2^CNT_W without flag.
REQ-025 sat_en=0: accumulate wraps modulo 2^ACC_W; signed overflow sets that lane's ovf.
REQ-026 sat_en=1: result clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1); clamping sets ovf.
REQ-027 FSM states IDLE, ACCUM, DRAIN, OUT; in_ready=1 only in IDLE and ACCUM.
REQ-028 IDLE->ACCUM on accepted beat without flush; ACCUM stays while beats arrive.
REQ-029 IDLE/ACCUM->DRAIN when flush=1; a beat accepted the same cycle is included in the snapshot.
REQ-030 DRAIN->OUT once stages 1 and 2 are empty (at most 2 cycles); out_valid=1 in OUT only.
REQ-031 acc_out, skip_count, ovf are always the live registers; stable throughout OUT.
REQ-032 OUT->IDLE on out_valid && out_ready; if clear_on_read of the flush cycle's exec_hints was 1, same edge zeroes all accumulators, skip counters, ovf.
REQ-033 out_valid held with stable data until out_ready; no beats accepted in DRAIN or OUT.
REQ-034 flush in IDLE with empty pipeline: DRAIN lasts 1 cycle, then OUT.

Reset
REQ-035 reset=1 at a clock edge: state IDLE, pipeline valid bits cleared (in-flight beats discarded), all acc, skip_count, ovf = 0, out_valid=0; in_ready=1 the cycle after reset deasserts; reset has priority over all other inputs, including mid-DRAIN/OUT.

Verification
REQ-036 LANES=4, DOT, skip off, 3 beats lane0 w=01 x=01 -> lane0 acc=3 two cycles after last beat; flush -> out_valid, acc_out lane0=3.
REQ-037 DOT, zero_skip_en=1, lane1 w=00 x=10 for 5 beats -> lane1 acc=0, skip_count lane1=5; lane2 w=10 x=01 -> acc=-5.
REQ-038 ACC_W=8, sat_en=1, 130 beats of +1 -> acc=127, ovf=1; sat_en=0 same stimulus -> acc=-126, ovf=1.
REQ-039 MUL after DOT acc=7, beat w=10 x=10 -> acc=+1; op_mode 8'h00 beat -> acc unchanged.
REQ-040 flush with out_ready=0 for 4 cycles -> out_valid and acc_out stable, in_ready=0; out_ready=1 with clear_on_read=1 -> all zero, IDLE next cycle.
REQ-041 reset asserted in OUT with 1 beat in stage 1 -> next cycle all outputs 0, out_valid=0, in_ready=1.
